// File: rtl/ntt_layer_sched.sv
// Butterfly scheduler for a full NTT / InvNTT pass over one polynomial.
// Issues one butterfly per cycle, layer by layer, with the read pair {j, j+L}
// and zeta address. Each pair is queued in a small FIFO until the BFU returns
// its result. Between layers the pipeline is drained so that a layer never
// reads a word that the previous layer has not yet written back.
module ntt_layer_sched #(
  parameter int ADDR_W     = 7,
  parameter int BFU_LAT    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              selKD_i,
  input  logic              selNTT_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addrA_o,
  output logic [ADDR_W-1:0] rd_addrB_o,
  input  logic [31:0]       rd_dataA_i,
  input  logic [31:0]       rd_dataB_i,
  output logic              bfu_valid_o,
  output logic [31:0]       bfu_srcA_o,
  output logic [31:0]       bfu_srcB_o,
  output logic [15:0]       bfu_zeta_addr_o,
  output logic              bfu_selKD_o,
  output logic              bfu_selNTT_o,
  output logic              bfu_flush_o,
  input  logic              bfu_valid_i,
  input  logic [31:0]       bfu_resA_i,
  input  logic [31:0]       bfu_resB_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addrA_o,
  output logic [ADDR_W-1:0] wr_addrB_o,
  output logic [31:0]       wr_dataA_o,
  output logic [31:0]       wr_dataB_o
);

  localparam int HALF  = 1 << (ADDR_W - 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // BFU latency only constrains the FIFO depth chosen by the integrator.
  localparam int unused_bfu_lat = BFU_LAT;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          layer_q, layer_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic                selKD_q, selNTT_q;
  logic                err_q, flush_q, bfu_valid_q;
  logic [15:0]         zeta_q;

  logic [2*ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr_q, rptr_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                active, abort_act, start_acc;
  logic                fifo_full, fifo_empty, issue, pop;
  logic [7:0]          shamt;
  logic [ADDR_W-1:0]   len_w, group_w, addr_j, addr_jl;
  logic [2*ADDR_W-1:0] fifo_head;

  assign active     = (state_q != S_IDLE);
  assign abort_act  = abort_i & active;
  assign start_acc  = (state_q == S_IDLE) & start_i;
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign issue      = (state_q == S_ISSUE) & ~fifo_full & ~abort_i;
  assign pop        = bfu_valid_i & ~fifo_empty & ~abort_act;

  // Butterfly address generation: L = 2^shamt, j = group*2L + (k mod L).
  always_comb begin
    shamt   = selNTT_q ? (8'(ADDR_W - 1) - layer_q) : layer_q;
    len_w   = ADDR_W'(1) << shamt;
    group_w = k_q >> shamt;
    addr_j  = (group_w << (shamt + 8'd1)) | (k_q & (len_w - ADDR_W'(1)));
    addr_jl = addr_j + len_w;
  end

  // Next-state logic: issue a layer, drain it, advance or finish; abort wins.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          layer_d = '0;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          k_d = k_q + ADDR_W'(1);
          if (k_q == ADDR_W'(HALF - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty || (pop && (cnt_q == CNT_W'(1)))) begin
          if (layer_q < 8'(ADDR_W - 1)) begin
            layer_d = layer_q + 8'd1;
            k_d     = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_act) state_d = S_IDLE;
  end

  // FSM state, layer index and butterfly counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      k_q     <= k_d;
    end
  end

  // Mode latch, sticky error, flush pulse and BFU-aligned valid/zeta.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      selKD_q     <= 1'b0;
      selNTT_q    <= 1'b0;
      err_q       <= 1'b0;
      flush_q     <= 1'b0;
      bfu_valid_q <= 1'b0;
      zeta_q      <= '0;
    end else begin
      if (start_acc) begin
        selKD_q  <= selKD_i;
        selNTT_q <= selNTT_i;
      end
      if (start_acc)                      err_q <= 1'b0;
      else if (bfu_valid_i && fifo_empty) err_q <= 1'b1;
      flush_q     <= abort_act;
      bfu_valid_q <= issue;
      if (issue) zeta_q <= {layer_q, 8'(group_w)};
    end
  end

  // Write-back FIFO pointers and occupancy; abort empties it.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_act) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (issue) wptr_q <= (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      if (pop)   rptr_q <= (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      if (issue && !pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (pop && !issue) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // FIFO storage of in-flight write-back address pairs.
  always_ff @(posedge clk_i) begin
    if (issue) fifo_mem[wptr_q] <= {addr_j, addr_jl};
  end

  assign fifo_head = fifo_mem[rptr_q];

  assign busy_o          = active;
  assign done_o          = (state_q == S_DONE);
  assign err_o           = err_q;
  assign rd_en_o         = issue;
  assign rd_addrA_o      = issue ? addr_j  : '0;
  assign rd_addrB_o      = issue ? addr_jl : '0;
  assign bfu_valid_o     = bfu_valid_q;
  assign bfu_srcA_o      = rd_dataA_i;
  assign bfu_srcB_o      = rd_dataB_i;
  assign bfu_zeta_addr_o = zeta_q;
  assign bfu_selKD_o     = selKD_q;
  assign bfu_selNTT_o    = selNTT_q;
  assign bfu_flush_o     = flush_q;
  assign wr_en_o         = bfu_valid_i & active;
  assign wr_addrA_o      = fifo_empty ? '0 : fifo_head[2*ADDR_W-1:ADDR_W];
  assign wr_addrB_o      = fifo_empty ? '0 : fifo_head[ADDR_W-1:0];
  assign wr_dataA_o      = bfu_resA_i;
  assign wr_dataB_o      = bfu_resB_i;

endmodule

// File: tb/tb_ntt_layer_sched.sv
// Directed bench for ntt_layer_sched: memory model, variable-latency BFU
// model whose butterfly folds in the zeta address, and a textbook
// loop-nest reference transform.
module tb_ntt_layer_sched;

  localparam int AW = 7;
  localparam int N  = 128;

  logic          clk = 1'b0;
  logic          rst_i, start_i, abort_i, selKD_i, selNTT_i;
  logic          busy_o, done_o, err_o, rd_en_o;
  logic [AW-1:0] rd_addrA_o, rd_addrB_o;
  logic [31:0]   rd_dataA_i, rd_dataB_i;
  logic          bfu_valid_o;
  logic [31:0]   bfu_srcA_o, bfu_srcB_o;
  logic [15:0]   bfu_zeta_addr_o;
  logic          bfu_selKD_o, bfu_selNTT_o, bfu_flush_o;
  logic          bfu_valid_i;
  logic [31:0]   bfu_resA_i, bfu_resB_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addrA_o, wr_addrB_o;
  logic [31:0]   wr_dataA_o, wr_dataB_o;

  ntt_layer_sched #(.ADDR_W(AW), .BFU_LAT(4), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .selKD_i(selKD_i), .selNTT_i(selNTT_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_en_o(rd_en_o), .rd_addrA_o(rd_addrA_o), .rd_addrB_o(rd_addrB_o),
    .rd_dataA_i(rd_dataA_i), .rd_dataB_i(rd_dataB_i),
    .bfu_valid_o(bfu_valid_o), .bfu_srcA_o(bfu_srcA_o), .bfu_srcB_o(bfu_srcB_o),
    .bfu_zeta_addr_o(bfu_zeta_addr_o), .bfu_selKD_o(bfu_selKD_o),
    .bfu_selNTT_o(bfu_selNTT_o), .bfu_flush_o(bfu_flush_o),
    .bfu_valid_i(bfu_valid_i), .bfu_resA_i(bfu_resA_i), .bfu_resB_i(bfu_resB_i),
    .wr_en_o(wr_en_o), .wr_addrA_o(wr_addrA_o), .wr_addrB_o(wr_addrB_o),
    .wr_dataA_o(wr_dataA_o), .wr_dataB_o(wr_dataB_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient memory: registered read, write in the bfu_valid_i cycle.
  logic [31:0] mem [0:N-1];
  logic [31:0] gold [0:N-1];
  logic        init_req = 1'b0;
  logic [31:0] init_seed = 32'd0;
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < N; i++) mem[i] <= 32'(i) * init_seed + 32'h0000_9e37;
    end else begin
      if (rd_en_o) begin
        rd_dataA_i <= mem[rd_addrA_o];
        rd_dataB_i <= mem[rd_addrB_o];
      end
      if (wr_en_o) begin
        mem[wr_addrA_o] <= wr_dataA_o;
        mem[wr_addrB_o] <= wr_dataB_o;
      end
    end
  end

  // BFU model: A' = A + B + zeta_addr, B' = A - B, after bfu_lat cycles.
  int          bfu_lat = 4;
  logic        inj_v = 1'b0;
  logic        pv [0:15];
  logic [31:0] pa [0:15];
  logic [31:0] pb [0:15];
  always @(posedge clk) begin
    if (bfu_flush_o || rst_i) begin
      for (int i = 0; i < 16; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= bfu_valid_o;
      pa[0] <= bfu_srcA_o + bfu_srcB_o + {16'h0, bfu_zeta_addr_o};
      pb[0] <= bfu_srcA_o - bfu_srcB_o;
      for (int i = 1; i < 16; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end
  assign bfu_valid_i = (pv[bfu_lat-1] & ~bfu_flush_o) | inj_v;
  assign bfu_resA_i  = pa[bfu_lat-1];
  assign bfu_resB_i  = pb[bfu_lat-1];

  // Monitor: per-run event logs indexed by cycle relative to the start cycle.
  int          t0 = 0;
  logic        clr_logs = 1'b0;
  int          mrel;
  logic        rdv [0:1023];
  int          rda [0:1023];
  int          rdb [0:1023];
  logic        zv  [0:1023];
  int          zl  [0:1023];
  int          rd_cnt, wr_cnt, wr_late, done_cnt, done_at, busy_cnt, busy_first, flush_at;
  always @(negedge clk) begin
    if (clr_logs) begin
      for (int i = 0; i < 1024; i++) begin
        rdv[i] = 1'b0; rda[i] = -1; rdb[i] = -1; zv[i] = 1'b0; zl[i] = -1;
      end
      rd_cnt = 0; wr_cnt = 0; wr_late = 0; done_cnt = 0; done_at = -1;
      busy_cnt = 0; busy_first = -1; flush_at = -1;
    end else begin
      mrel = cyc - t0;
      if (mrel >= 0 && mrel < 1024) begin
        if (rd_en_o) begin
          rdv[mrel] = 1'b1; rda[mrel] = int'(rd_addrA_o); rdb[mrel] = int'(rd_addrB_o);
        end
        if (bfu_valid_o) begin
          zv[mrel] = 1'b1; zl[mrel] = int'(bfu_zeta_addr_o);
        end
      end
      if (rd_en_o) rd_cnt++;
      if (wr_en_o) begin
        wr_cnt++;
        if (mrel >= 101) wr_late++;
      end
      if (done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = mrel;
      end
      if (busy_o) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = mrel;
      end
      if (bfu_flush_o && flush_at < 0) flush_at = mrel;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic init_mem(input logic [31:0] seed);
    @(posedge clk); #1;
    init_seed = seed;
    init_req  = 1'b1;
    for (int i = 0; i < N; i++) gold[i] = 32'(i) * seed + 32'h0000_9e37;
    @(posedge clk); #1;
    init_req = 1'b0;
  endtask

  // Reference transform as the usual three-level loop nest.
  task automatic golden(input bit ntt);
    int len, grp;
    logic [31:0] a, b;
    for (int l = 0; l < AW; l++) begin
      len = ntt ? (64 >> l) : (1 << l);
      for (int st = 0; st < N; st += 2 * len) begin
        grp = st / (2 * len);
        for (int j = st; j < st + len; j++) begin
          a = gold[j];
          b = gold[j + len];
          gold[j]       = a + b + 32'((l << 8) | grp);
          gold[j + len] = a - b;
        end
      end
    end
  endtask

  function automatic int mem_errs();
    int e = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== gold[i]) e++;
    return e;
  endfunction

  task automatic do_start(input bit ntt);
    @(posedge clk); #1;
    clr_logs = 1'b1;
    @(negedge clk); #1;
    clr_logs = 1'b0;
    @(posedge clk); #1;
    selNTT_i = ntt;
    selKD_i  = 1'b1;
    start_i  = 1'b1;
    t0       = cyc;
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - t0 < r) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int zbad, zcnt;

  initial begin
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; selKD_i = 1'b0; selNTT_i = 1'b0;
    rd_dataA_i = '0; rd_dataB_i = '0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  done_o, 0);
    chk("rst_err",   err_o, 0);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_flush", bfu_flush_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_zeta",  bfu_zeta_addr_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // NTT, BFU latency 4
    init_mem(32'd3);
    golden(1'b1);
    do_start(1'b1);
    wait_done(1500);
    chk("ntt_done_at",    done_at, 484);
    chk("ntt_done_cnt",   done_cnt, 1);
    chk("ntt_busy_first", busy_first, 1);
    chk("ntt_busy_cnt",   busy_cnt, 484);
    chk("ntt_rd_cnt",     rd_cnt, 448);
    chk("ntt_wr_cnt",     wr_cnt, 448);
    chk("ntt_rd0_idle",   rdv[0], 0);
    chk("ntt_rd1_A",      rda[1], 0);
    chk("ntt_rd1_B",      rdb[1], 64);
    chk("ntt_rd2_A",      rda[2], 1);
    chk("ntt_rd64_A",     rda[64], 63);
    chk("ntt_rd64_B",     rdb[64], 127);
    chk("ntt_gap69",      rdv[69], 0);
    chk("ntt_l1_A",       rda[70], 0);
    chk("ntt_l1_B",       rdb[70], 32);
    chk("ntt_l1_zeta",    zl[71], 16'h0100);
    chk("ntt_l1k32_A",    rda[102], 64);
    chk("ntt_l1k32_zeta", zl[103], 16'h0101);
    zbad = 0; zcnt = 0;
    for (int r = 2; r <= 65; r++) if (zv[r]) begin
      zcnt++;
      if (zl[r] != 0) zbad++;
    end
    chk("ntt_l0_zeta_cnt", zcnt, 64);
    chk("ntt_l0_zeta_bad", zbad, 0);
    chk("ntt_mem", mem_errs(), 0);

    // InvNTT, with an ignored start pulse mid-transform
    init_mem(32'd5);
    golden(1'b0);
    do_start(1'b0);
    wait_rel(200);
    start_i = 1'b1; selNTT_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; selNTT_i = 1'b0;
    wait_done(1500);
    chk("inv_sel_ntt",   bfu_selNTT_o, 0);
    chk("inv_rd1_A",     rda[1], 0);
    chk("inv_rd1_B",     rdb[1], 1);
    chk("inv_rd2_A",     rda[2], 2);
    chk("inv_rd2_B",     rdb[2], 3);
    chk("inv_zeta3",     zl[3], 1);
    chk("inv_zeta4",     zl[4], 2);
    chk("inv_l6_A",      rda[415], 0);
    chk("inv_l6_B",      rdb[415], 64);
    chk("inv_l6_zeta",   zl[416], 16'h0600);
    chk("inv_done_at",   done_at, 484);
    chk("inv_done_cnt",  done_cnt, 1);
    chk("inv_mem", mem_errs(), 0);

    // Abort at cycle 100, then a fresh transform
    init_mem(32'd9);
    do_start(1'b1);
    wait_rel(100);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    wait_rel(109);
    @(negedge clk); #1;
    chk("abort_flush_at", flush_at, 101);
    chk("abort_busy_cnt", busy_cnt, 100);
    chk("abort_busy_now", busy_o, 0);
    chk("abort_no_done",  done_cnt, 0);
    chk("abort_no_wr",    wr_late, 0);
    chk("abort_err",      err_o, 0);
    init_mem(32'd11);
    golden(1'b1);
    do_start(1'b1);
    wait_done(1500);
    chk("restart_done_at", done_at, 484);
    chk("restart_mem", mem_errs(), 0);

    // Stray BFU result while idle sets the sticky error
    @(posedge clk); #1;
    inj_v = 1'b1;
    @(posedge clk); #1;
    inj_v = 1'b0;
    @(negedge clk);
    chk("err_set", err_o, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", err_o, 1);

    // BFU latency 7 with an 8-entry FIFO: the start clears the error
    bfu_lat = 7;
    init_mem(32'd13);
    golden(1'b1);
    do_start(1'b1);
    @(negedge clk);
    chk("err_cleared", err_o, 0);
    wait_done(3000);
    chk("lat7_done_cnt", done_cnt, 1);
    chk("lat7_slower",   (done_at > 484) ? 1 : 0, 1);
    chk("lat7_rd8",      rdv[8], 1);
    chk("lat7_stall9",   rdv[9], 0);
    chk("lat7_rd10",     rdv[10], 1);
    chk("lat7_rd10_A",   rda[10], 8);
    chk("lat7_rd_cnt",   rd_cnt, 448);
    chk("lat7_wr_cnt",   wr_cnt, 448);
    chk("lat7_err",      err_o, 0);
    chk("lat7_mem", mem_errs(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
